// File: rtl/sd_load_sched.sv
// sd_load_sched: sequences multi-sector SD loads.
// Waits for card init, then issues one read per sector to the sector-read
// engine. A failed read or a read timeout re-issues the same sector up to
// MAX_RETRY times. Finishes with a done pulse or a sticky error flag.
module sd_load_sched #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic        clk_ref,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_sector,
  input  logic [15:0] sector_count,
  input  logic        sd_init_done,
  output logic        rd_start,
  output logic [31:0] rd_sec_addr,
  input  logic        rd_done,
  input  logic        rd_err,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] sectors_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_RD   = 3'd3,
    S_FINISH    = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [23:0] TIMER_LAST = TIMEOUT_CYC - 24'd1;
  localparam logic [23:0] TIMER_MAX  = 24'hFF_FFFF;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_base;
  logic [15:0] r_count;
  logic [15:0] r_sectors_done;
  logic [15:0] w_sectors_done_next;
  logic [1:0]  r_retry;
  logic [1:0]  w_retry_next;
  logic [23:0] r_timer;

  logic        r_rd_start;
  logic [31:0] r_rd_sec_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic        w_timer_hit;
  logic        w_timer_run;
  logic        w_sector_last;

  // Timer runs only while waiting on the card or on a sector read.
  assign w_timer_run   = (r_state == S_WAIT_INIT) || (r_state == S_WAIT_RD);
  assign w_timer_hit   = (r_timer == TIMER_LAST);
  // A clean read of this sector completes the load.
  assign w_sector_last = ((r_sectors_done + 16'd1) == r_count);

  // Next-state, progress counters and start acceptance.
  always_comb begin
    w_state_next        = r_state;
    w_sectors_done_next = r_sectors_done;
    w_retry_next        = r_retry;
    w_accept            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept            = 1'b1;
          w_sectors_done_next = 16'd0;
          w_retry_next        = 2'd0;
          w_state_next        = (sector_count == 16'd0) ? S_FINISH : S_WAIT_INIT;
        end
      end
      S_WAIT_INIT: begin
        // Card readiness wins over a timeout landing on the same cycle.
        if (sd_init_done) begin
          w_state_next = S_ISSUE;
        end else if (w_timer_hit) begin
          w_state_next = S_FAIL;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        // rd_done is checked first so a completion on the timeout cycle counts.
        if (rd_done && !rd_err) begin
          w_sectors_done_next = r_sectors_done + 16'd1;
          w_retry_next        = 2'd0;
          w_state_next        = w_sector_last ? S_FINISH : S_ISSUE;
        end else if (rd_done || w_timer_hit) begin
          if (r_retry < MAX_RETRY) begin
            w_retry_next = r_retry + 2'd1;
            w_state_next = S_ISSUE;
          end else begin
            w_state_next = S_FAIL;
          end
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      S_FAIL: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Load parameters are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_base  <= 32'd0;
      r_count <= 16'd0;
    end else if (w_accept) begin
      r_base  <= start_sector;
      r_count <= sector_count;
    end
  end

  // Sector progress and per-sector retry count.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_sectors_done <= 16'd0;
      r_retry        <= 2'd0;
    end else begin
      r_sectors_done <= w_sectors_done_next;
      r_retry        <= w_retry_next;
    end
  end

  // Wait timer: zero on every state change, saturates instead of wrapping.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_timer <= 24'd0;
    end else if (w_state_next != r_state) begin
      r_timer <= 24'd0;
    end else if (w_timer_run && (r_timer != TIMER_MAX)) begin
      r_timer <= r_timer + 24'd1;
    end
  end

  // Registered outputs, decoded from the state being entered so they line up
  // with the state itself; the address is held until the next issue.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_rd_start    <= 1'b0;
      r_rd_sec_addr <= 32'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_rd_start <= (w_state_next == S_ISSUE);
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (w_state_next == S_FINISH);
      if (w_state_next == S_ISSUE) begin
        r_rd_sec_addr <= r_base + {16'd0, w_sectors_done_next};
      end
    end
  end

  // Sticky error: set on entering FAIL, cleared only by an accepted start.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= 1'b0;
    end else if (w_state_next == S_FAIL) begin
      r_error <= 1'b1;
    end
  end

  assign rd_start     = r_rd_start;
  assign rd_sec_addr  = r_rd_sec_addr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign sectors_done = r_sectors_done;

endmodule

// File: tb/tb_sd_load_sched.sv
// tb_sd_load_sched: plays the SD init engine and sector-read engine around
// sd_load_sched, predicting issue addresses, issue spacing and the final
// outcome of every load from a sector/retry model.
module tb_sd_load_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] start_sector;
  logic [15:0] sector_count;
  logic        sd_init_done;
  logic        rd_start;
  logic [31:0] rd_sec_addr;
  logic        rd_done;
  logic        rd_err;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] sectors_done;

  int checks = 0;
  int errors = 0;
  int n_rd   = 0;
  int n_done = 0;

  localparam int TO_CYC = 16;
  localparam int RETRIES = 3;

  sd_load_sched #(
    .TIMEOUT_CYC(24'd16),
    .MAX_RETRY  (2'd3)
  ) dut (
    .clk_ref     (clk),
    .rst         (rst),
    .start       (start),
    .start_sector(start_sector),
    .sector_count(sector_count),
    .sd_init_done(sd_init_done),
    .rd_start    (rd_start),
    .rd_sec_addr (rd_sec_addr),
    .rd_done     (rd_done),
    .rd_err      (rd_err),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .sectors_done(sectors_done)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rd_start === 1'b1) n_rd++;
    if (done === 1'b1) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 random responses, 1 always rd_err, 2 never respond,
  //       3 clean on the timeout cycle, 4 clean with short delay.
  // init_delay: cycles sd_init_done stays low; >= TO_CYC means it never rises.
  task automatic run_load(input logic [31:0] base, input logic [15:0] cnt,
                          input int mode, input int init_delay);
    int ok, retry, issues, rd0, dn0, n, d, resp, r, exp_gap, exp_kind, obs_kind, iter;
    bit spur;
    string outcome;
    rd0 = n_rd; dn0 = n_done; ok = 0; retry = 0; issues = 0; outcome = "abort";
    @(negedge clk);
    start = 1'b1; start_sector = base; sector_count = cnt;
    if (init_delay > 0) sd_init_done = 1'b0;
    @(negedge clk);
    start = 1'b0; start_sector = $urandom; sector_count = 16'($urandom);
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    chk("sectors_cleared", sectors_done, 0);
    if (cnt == 16'd0) begin
      chk("zero_done", done, 1);
      @(negedge clk);
      chk("zero_done_end", done, 0);
      chk("zero_busy_end", busy, 0);
      outcome = "done";
    end else if (init_delay >= TO_CYC) begin
      n = 0;
      do begin @(negedge clk); n++; end while (error !== 1'b1 && n < 40);
      chk("init_timeout_cycles", n, TO_CYC);
      chk("init_timeout_error", error, 1);
      chk("init_timeout_no_done", done, 0);
      @(negedge clk);
      sd_init_done = 1'b1;
      chk("init_timeout_idle", busy, 0);
      chk("init_timeout_error_hold", error, 1);
      outcome = "error";
    end else begin
      if (init_delay > 0) begin
        repeat (init_delay) @(negedge clk);
        sd_init_done = 1'b1;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (rd_start !== 1'b1 && n < 40);
      chk("first_issue", rd_start, 1);
      iter = 0;
      while (rd_start === 1'b1 && iter < 200) begin
        iter++;
        issues++;
        chk("issue_addr", rd_sec_addr, base + 32'(ok));
        chk("issue_sectors_done", sectors_done, ok);
        chk("issue_busy", busy, 1);
        case (mode)
          1: begin resp = 1; d = $urandom_range(1, TO_CYC); end
          2: begin resp = 2; d = 1; end
          3: begin resp = 0; d = TO_CYC; end
          4: begin resp = 0; d = $urandom_range(1, 6); end
          default: begin
            r = $urandom_range(0, 19);
            if (r < 14)      begin resp = 0; d = $urandom_range(1, 8); end
            else if (r < 17) begin resp = 1; d = $urandom_range(1, TO_CYC); end
            else if (r < 19) begin resp = 2; d = 1; end
            else             begin resp = 0; d = TO_CYC; end
          end
        endcase
        spur = (mode == 0) && ($urandom_range(0, 3) == 0);
        for (int k = 1; k <= d; k++) begin
          @(negedge clk);
          start = 1'b0;
          if (k == 1) begin
            chk("rd_start_one_cycle", rd_start, 0);
            if (spur) begin
              start = 1'b1; start_sector = $urandom;
              sector_count = 16'($urandom_range(1, 50));
            end
          end
          if (k == d && resp != 2) begin
            rd_done = 1'b1;
            rd_err  = (resp == 1);
          end
        end
        exp_gap = (resp == 2) ? TO_CYC + 1 : d + 1;
        if (resp == 0) begin
          ok++; retry = 0;
          exp_kind = (ok == int'(cnt)) ? 2 : 1;
        end else if (retry < RETRIES) begin
          retry++; exp_kind = 1;
        end else begin
          exp_kind = 3;
        end
        n = 0;
        do begin
          @(negedge clk); n++;
          start = 1'b0; rd_done = 1'b0; rd_err = 1'b0;
        end while (!(rd_start === 1'b1 || done === 1'b1 || error === 1'b1) && n < 40);
        obs_kind = (rd_start === 1'b1) ? 1 : (done === 1'b1) ? 2 : (error === 1'b1) ? 3 : 0;
        chk("event_kind", obs_kind, exp_kind);
        chk("event_gap", d + n, exp_gap);
        if (obs_kind == 2 && exp_kind == 2) begin
          chk("final_sectors_done", sectors_done, cnt);
          chk("final_no_error", error, 0);
          outcome = "done";
        end else if (obs_kind == 3 && exp_kind == 3) begin
          chk("fail_sectors_done", sectors_done, ok);
          chk("fail_no_done", done, 0);
          outcome = "error";
        end
      end
      if (outcome != "abort") begin
        @(negedge clk);
        chk("end_idle", busy, 0);
        chk("end_done_low", done, 0);
        chk("end_sectors_hold", sectors_done, ok);
      end
    end
    sd_init_done = 1'b1;
    chk("done_pulses", n_done - dn0, (outcome == "done") ? 1 : 0);
    chk("rd_start_count", n_rd - rd0, issues);
    $display("load base=0x%08h count=%0d mode=%0d init_delay=%0d issues=%0d result=%s",
             base, cnt, mode, init_delay, issues, outcome);
  endtask

  initial begin
    int dn0, n;
    rst = 1'b1; start = 1'b0; start_sector = 32'd0; sector_count = 16'd0;
    sd_init_done = 1'b1; rd_done = 1'b0; rd_err = 1'b0;
    #1;
    chk("reset_rd_start", rd_start, 0);
    chk("reset_addr", rd_sec_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_sectors", sectors_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_load(32'h0000_0100, 16'd3, 4, 0);
    run_load(32'h0000_1234, 16'd0, 4, 0);
    run_load(32'h0000_0040, 16'd2, 1, 0);
    run_load(32'hFFFF_FFFF, 16'd2, 4, 0);
    run_load(32'h0000_0500, 16'd1, 2, 0);
    run_load(32'h0000_0600, 16'd2, 3, 0);
    run_load(32'h0000_0700, 16'd2, 4, TO_CYC);

    // rd_done while idle must not start anything; error stays sticky.
    @(negedge clk); rd_done = 1'b1;
    @(negedge clk); rd_done = 1'b0;
    chk("idle_rd_done_busy", busy, 0);
    chk("idle_rd_done_error_hold", error, 1);

    // Reset during the read of sector 1.
    dn0 = n_done;
    @(negedge clk); start = 1'b1; start_sector = 32'h200; sector_count = 16'd3;
    @(negedge clk); start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (rd_start !== 1'b1 && n < 40);
    chk("rst_case_issue0", rd_sec_addr, 32'h200);
    @(negedge clk); rd_done = 1'b1;
    @(negedge clk); rd_done = 1'b0;
    chk("rst_case_issue1", rd_start, 1);
    chk("rst_case_addr1", rd_sec_addr, 32'h201);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rd_start", rd_start, 0);
    chk("midrst_addr", rd_sec_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_sectors", sectors_done, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_idle", busy, 0);
    chk("postrst_no_done", n_done - dn0, 0);
    $display("load base=0x%08h count=3 aborted by reset", 32'h200);
    run_load(32'h0000_0300, 16'd2, 4, 0);

    // Randomized loads.
    for (int i = 0; i < 30; i++) begin
      run_load($urandom, 16'($urandom_range(0, 6)), 0,
               ($urandom_range(0, 7) == 0) ? TO_CYC : $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
